// File: rtl/tsi_pkg.sv
// Shared definitions for the TSI memory responder: command encodings and FSM states.
package tsi_pkg;

  localparam int TSI_WORD_BITS = 32;

  localparam logic [TSI_WORD_BITS-1:0] TSI_CMD_READ  = 32'd0;
  localparam logic [TSI_WORD_BITS-1:0] TSI_CMD_WRITE = 32'd1;

  typedef enum logic [3:0] {
    S_CMD     = 4'd0,
    S_ADDR_LO = 4'd1,
    S_ADDR_HI = 4'd2,
    S_LEN_LO  = 4'd3,
    S_LEN_HI  = 4'd4,
    S_WDATA   = 4'd5,
    S_WREQ    = 4'd6,
    S_RREQ    = 4'd7,
    S_RRESP   = 4'd8,
    S_RSEND   = 4'd9
  } tsi_state_e;

endpackage

// File: rtl/tsi_mem_responder.sv
// Parses host TSI packets (cmd, 64-bit address, 64-bit length, data) and turns
// them into one memory request per word, streaming read data back to the host.
module tsi_mem_responder
  import tsi_pkg::*;
#(
  parameter int ADDR_BITS      = 64,
  parameter bit ERR_ON_BAD_CMD = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tsi_in_valid,
  output logic                     tsi_in_ready,
  input  logic [TSI_WORD_BITS-1:0] tsi_in_bits,
  output logic                     tsi_out_valid,
  input  logic                     tsi_out_ready,
  output logic [TSI_WORD_BITS-1:0] tsi_out_bits,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_wen,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic [TSI_WORD_BITS-1:0] mem_req_wdata,
  input  logic                     mem_resp_valid,
  output logic                     mem_resp_ready,
  input  logic [TSI_WORD_BITS-1:0] mem_resp_rdata,
  output logic                     busy,
  output logic                     bad_cmd
);

  tsi_state_e               state_r;
  logic                     is_write_r;
  logic [ADDR_BITS-1:0]     addr_r;
  logic [63:0]              count_r;
  logic [TSI_WORD_BITS-1:0] wdata_r;
  logic [TSI_WORD_BITS-1:0] rdata_r;
  logic                     bad_cmd_r;

  logic                     in_fire_s;
  logic                     req_fire_s;
  logic                     resp_fire_s;
  logic                     out_fire_s;
  logic [63:0]              addr_ext_s;
  logic [ADDR_BITS-1:0]     addr_lo_load_s;
  logic [ADDR_BITS-1:0]     addr_hi_load_s;
  logic [ADDR_BITS-1:0]     addr_next_s;

  assign in_fire_s   = tsi_in_valid & tsi_in_ready;
  assign req_fire_s  = mem_req_valid & mem_req_ready;
  assign resp_fire_s = mem_resp_valid & mem_resp_ready;
  assign out_fire_s  = tsi_out_valid & tsi_out_ready;

  // The low address word clears the upper half, so the high word can simply be OR-ed in.
  assign addr_ext_s     = 64'(addr_r);
  assign addr_lo_load_s = ADDR_BITS'({32'd0, tsi_in_bits});
  assign addr_hi_load_s = ADDR_BITS'({tsi_in_bits, 32'd0} | addr_ext_s);
  assign addr_next_s    = addr_r + ADDR_BITS'(3'd4);

  // Every output is a decode of the state register or a plain register.
  assign tsi_in_ready   = (state_r == S_CMD)    || (state_r == S_ADDR_LO) ||
                          (state_r == S_ADDR_HI) || (state_r == S_LEN_LO)  ||
                          (state_r == S_LEN_HI)  || (state_r == S_WDATA);
  assign mem_req_valid  = (state_r == S_WREQ) || (state_r == S_RREQ);
  assign mem_req_wen    = (state_r == S_WREQ);
  assign mem_req_addr   = addr_r;
  assign mem_req_wdata  = wdata_r;
  assign mem_resp_ready = (state_r == S_RRESP);
  assign tsi_out_valid  = (state_r == S_RSEND);
  assign tsi_out_bits   = rdata_r;
  assign busy           = (state_r != S_CMD);
  assign bad_cmd        = bad_cmd_r;

  // Packet parser and memory sequencer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_CMD;
      is_write_r <= 1'b0;
      addr_r     <= '0;
      count_r    <= 64'd0;
      wdata_r    <= 32'd0;
      rdata_r    <= 32'd0;
      bad_cmd_r  <= 1'b0;
    end else begin
      case (state_r)
        S_CMD: begin
          if (in_fire_s) begin
            if (tsi_in_bits == TSI_CMD_READ) begin
              is_write_r <= 1'b0;
              state_r    <= S_ADDR_LO;
            end else if (tsi_in_bits == TSI_CMD_WRITE) begin
              is_write_r <= 1'b1;
              state_r    <= S_ADDR_LO;
            end else if (ERR_ON_BAD_CMD) begin
              bad_cmd_r <= 1'b1;
            end
          end
        end
        S_ADDR_LO: begin
          if (in_fire_s) begin
            addr_r  <= addr_lo_load_s;
            state_r <= S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          if (in_fire_s) begin
            addr_r  <= addr_hi_load_s;
            state_r <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (in_fire_s) begin
            count_r <= {32'd0, tsi_in_bits};
            state_r <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (in_fire_s) begin
            count_r <= {tsi_in_bits, count_r[31:0]};
            state_r <= is_write_r ? S_WDATA : S_RREQ;
          end
        end
        S_WDATA: begin
          if (in_fire_s) begin
            wdata_r <= tsi_in_bits;
            state_r <= S_WREQ;
          end
        end
        S_WREQ: begin
          if (req_fire_s) begin
            addr_r <= addr_next_s;
            if (count_r == 64'd0) begin
              state_r <= S_CMD;
            end else begin
              count_r <= count_r - 64'd1;
              state_r <= S_WDATA;
            end
          end
        end
        S_RREQ: begin
          if (req_fire_s) begin
            state_r <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (resp_fire_s) begin
            rdata_r <= mem_resp_rdata;
            state_r <= S_RSEND;
          end
        end
        S_RSEND: begin
          if (out_fire_s) begin
            addr_r <= addr_next_s;
            if (count_r == 64'd0) begin
              state_r <= S_CMD;
            end else begin
              count_r <= count_r - 64'd1;
              state_r <= S_RREQ;
            end
          end
        end
        default: state_r <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_tsi_mem_responder.sv
// Randomized scoreboard bench for tsi_mem_responder with a word-level packet model
// and a behavioural memory that answers reads with random latency.
module tb_tsi_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        tsi_in_valid;
  logic        tsi_in_ready;
  logic [31:0] tsi_in_bits;
  logic        tsi_out_valid;
  logic        tsi_out_ready;
  logic [31:0] tsi_out_bits;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        busy;
  logic        bad_cmd;

  tsi_mem_responder #(.ADDR_BITS(64), .ERR_ON_BAD_CMD(1'b1)) dut (
    .clock(clock), .reset(reset),
    .tsi_in_valid(tsi_in_valid), .tsi_in_ready(tsi_in_ready), .tsi_in_bits(tsi_in_bits),
    .tsi_out_valid(tsi_out_valid), .tsi_out_ready(tsi_out_ready), .tsi_out_bits(tsi_out_bits),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .busy(busy), .bad_cmd(bad_cmd)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        wen;
    logic [63:0] addr;
    logic [31:0] data;
  } req_t;

  int          vectors = 0;
  int          miscompares = 0;
  req_t        exp_req[$];
  logic [31:0] exp_out[$];
  bit   [31:0] ref_mem [bit [63:0]];
  bit   [31:0] bus_mem [bit [63:0]];
  logic [31:0] pending[$];
  bit          stall_mode = 1'b0;

  function automatic logic [31:0] fill_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h6C3A_91E5;
  endfunction

  function automatic logic [31:0] ref_read(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill_word(a);
  endfunction

  function automatic logic [31:0] bus_read(input logic [63:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    return fill_word(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on each handshake and checks hold-while-stalled.
  bit   prev_req_hold = 1'b0;
  req_t prev_req;
  bit   prev_out_hold = 1'b0;
  logic [31:0] prev_out_bits;
  bit   prev_resp_fire = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      prev_req_hold  = 1'b0;
      prev_out_hold  = 1'b0;
      prev_resp_fire = 1'b0;
    end else begin
      if (prev_req_hold) begin
        check("req_hold_valid", {63'd0, mem_req_valid}, 64'd1);
        check("req_hold_addr", mem_req_addr, prev_req.addr);
        check("req_hold_wen", {63'd0, mem_req_wen}, {63'd0, prev_req.wen});
        if (prev_req.wen) check("req_hold_wdata", {32'd0, mem_req_wdata}, {32'd0, prev_req.data});
      end
      if (prev_out_hold) begin
        check("out_hold_valid", {63'd0, tsi_out_valid}, 64'd1);
        check("out_hold_bits", {32'd0, tsi_out_bits}, {32'd0, prev_out_bits});
      end
      if (prev_resp_fire) check("resp_to_out_latency", {63'd0, tsi_out_valid}, 64'd1);
      if (mem_req_valid || tsi_out_valid)
        check("req_and_send_overlap", {63'd0, mem_req_valid & tsi_out_valid}, 64'd0);
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          check("unexpected_mem_req", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          check("mem_req_wen", {63'd0, mem_req_wen}, {63'd0, e.wen});
          check("mem_req_addr", mem_req_addr, e.addr);
          if (e.wen) check("mem_req_wdata", {32'd0, mem_req_wdata}, {32'd0, e.data});
        end
      end
      if (tsi_out_valid && tsi_out_ready) begin
        if (exp_out.size() == 0) begin
          check("unexpected_tsi_out", {32'd0, tsi_out_bits}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("tsi_out_bits", {32'd0, tsi_out_bits}, {32'd0, exp_out.pop_front()});
        end
      end
      prev_req_hold  = mem_req_valid && !mem_req_ready;
      prev_req       = '{wen: mem_req_wen, addr: mem_req_addr, data: mem_req_wdata};
      prev_out_hold  = tsi_out_valid && !tsi_out_ready;
      prev_out_bits  = tsi_out_bits;
      prev_resp_fire = mem_resp_valid && mem_resp_ready;
    end
  end

  // Behavioural memory: random request back-pressure, random response delay, junk responses when idle.
  initial begin
    bit          req_fire, resp_fire, rst_seen, real_offer;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [31:0] req_wdata;
    real_offer     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'd0;
    forever begin
      @(negedge clock);
      rst_seen  = reset;
      req_fire  = !reset && mem_req_valid && mem_req_ready;
      resp_fire = !reset && mem_resp_valid && mem_resp_ready;
      req_wen   = mem_req_wen;
      req_addr  = mem_req_addr;
      req_wdata = mem_req_wdata;
      @(posedge clock);
      #1;
      if (rst_seen) begin
        pending.delete();
        real_offer = 1'b0;
      end else begin
        if (req_fire && req_wen) bus_mem[req_addr] = req_wdata;
        if (req_fire && !req_wen) pending.push_back(bus_read(req_addr));
        if (resp_fire && pending.size() > 0) begin
          void'(pending.pop_front());
          real_offer = 1'b0;
        end
      end
      mem_req_ready = ($urandom_range(0, 3) != 0);
      if (pending.size() > 0) begin
        if (!real_offer) begin
          mem_resp_valid = ($urandom_range(0, 2) != 0);
          real_offer     = mem_resp_valid;
        end
        mem_resp_rdata = pending[0];
      end else begin
        real_offer     = 1'b0;
        mem_resp_valid = ($urandom_range(0, 4) == 0);
        mem_resp_rdata = $urandom;
      end
    end
  end

  // Host-side read data sink: random ready, or five stall cycles per word in stall mode.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    tsi_out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_mode) begin
        if (tsi_out_valid && stall_cnt < 5) begin
          tsi_out_ready = 1'b0;
          stall_cnt++;
        end else if (tsi_out_valid) begin
          tsi_out_ready = 1'b1;
          stall_cnt = 0;
        end else begin
          tsi_out_ready = 1'b0;
          stall_cnt = 0;
        end
      end else begin
        tsi_out_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Offers one word and returns just after the posedge that accepted it.
  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clock);
      #1;
    end
    tsi_in_valid = 1'b1;
    tsi_in_bits  = w;
    do begin
      @(negedge clock);
      guard++;
    end while (!tsi_in_ready && guard < 500);
    if (!tsi_in_ready) check("tsi_in_ready_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1;
    tsi_in_valid = 1'b0;
    tsi_in_bits  = $urandom;
  endtask

  task automatic send_packet(input logic [31:0] cmd, input logic [63:0] addr, input logic [63:0] len,
                             input bit seq_data, input logic [31:0] base, input bit lat_chk);
    logic [31:0] d[$];
    logic [63:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 64'(4 * i);
      if (cmd == 32'd1) begin
        d.push_back(seq_data ? base + 32'(i) : $urandom);
        exp_req.push_back('{wen: 1'b1, addr: a, data: d[i]});
        ref_mem[a] = d[i];
      end else begin
        exp_req.push_back('{wen: 1'b0, addr: a, data: 32'd0});
        exp_out.push_back(ref_read(a));
      end
    end
    send_word(cmd);
    send_word(addr[31:0]);
    send_word(addr[63:32]);
    send_word(len[31:0]);
    send_word(len[63:32]);
    for (int i = 0; i < d.size(); i++) begin
      send_word(d[i]);
      if (lat_chk && i == 0) begin
        @(negedge clock);
        check("wdata_to_req_latency", {63'd0, mem_req_valid}, 64'd1);
      end
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while ((busy || exp_req.size() != 0 || exp_out.size() != 0) && guard < 3000);
    check({name, "_busy_done"}, {63'd0, busy}, 64'd0);
    check({name, "_queues_empty"}, 64'(exp_req.size() + exp_out.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_req.delete();
    exp_out.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [31:0] w;
    int guard;
    reset        = 1'b1;
    tsi_in_valid = 1'b0;
    tsi_in_bits  = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {63'd0, tsi_in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, tsi_out_valid}, 64'd0);
    check("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("rst_resp_ready", {63'd0, mem_resp_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_bad_cmd", {63'd0, bad_cmd}, 64'd0);
    @(posedge clock);
    #1;

    send_packet(32'd1, 64'h0000_0000_8000_0000, 64'd2, 1'b1, 32'hA, 1'b1);
    drain("write3");

    bus_mem[64'h1000] = 32'hDEAD_BEEF;
    ref_mem[64'h1000] = 32'hDEAD_BEEF;
    send_packet(32'd0, 64'h1000, 64'd0, 1'b0, 32'd0, 1'b0);
    drain("read1");

    stall_mode = 1'b1;
    send_packet(32'd0, 64'h2000, 64'd3, 1'b0, 32'd0, 1'b0);
    drain("read_stall");
    stall_mode = 1'b0;

    send_word(32'h7);
    @(negedge clock);
    check("badcmd_set", {63'd0, bad_cmd}, 64'd1);
    check("badcmd_idle", {63'd0, busy}, 64'd0);
    @(posedge clock);
    #1;
    send_packet(32'd1, 64'h5000, 64'd1, 1'b0, 32'd0, 1'b0);
    drain("after_badcmd");
    check("badcmd_sticky", {63'd0, bad_cmd}, 64'd1);

    send_packet(32'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 1'b0, 32'd0, 1'b0);
    drain("wrap");
    send_packet(32'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 1'b0, 32'd0, 1'b0);
    drain("wrap_readback");

    // Abandon a four-word write after its first word has been written.
    w = $urandom;
    exp_req.push_back('{wen: 1'b1, addr: 64'h3000, data: w});
    ref_mem[64'h3000] = w;
    send_word(32'd1);
    send_word(32'h3000);
    send_word(32'd0);
    send_word(32'd3);
    send_word(32'd0);
    send_word(w);
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!tsi_in_ready && guard < 500);
    check("abort_first_word_done", 64'(exp_req.size()), 64'd0);
    pulse_reset();
    @(negedge clock);
    check("abort_req_valid", {63'd0, mem_req_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_in_ready", {63'd0, tsi_in_ready}, 64'd1);
    check("abort_bad_cmd_cleared", {63'd0, bad_cmd}, 64'd0);
    @(posedge clock);
    #1;
    send_packet(32'd0, 64'h3000, 64'd1, 1'b0, 32'd0, 1'b0);
    drain("after_abort");

    for (int p = 0; p < 30; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_word(32'($urandom_range(2, 1000)));
        @(negedge clock);
        check("rand_badcmd", {63'd0, bad_cmd}, 64'd1);
        @(posedge clock);
        #1;
      end
      case ($urandom_range(0, 2))
        0:       a = 64'h4000 + 64'(4 * $urandom_range(0, 15));
        1:       a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(0, 3));
        default: a = {32'($urandom), 32'($urandom)} & ~64'd3;
      endcase
      send_packet(32'($urandom_range(0, 1)), a, 64'($urandom_range(0, 4)), 1'b0, 32'd0, 1'b0);
      drain("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
